// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, baud divisor and arbiter states.
// Imported by the transmitter side and by uart_tx_arbiter.
package uart_pkg;

  localparam int UART_BYTE_W = 8;
  // 27 MHz / 9600 baud
  localparam int BAUD_DIV = 2813;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: search starts one past last, wraps at N.
// Ports: req (candidates), last (previous winner), win, found.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   last,
  output logic [1:0]   win,
  output logic         found
);

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] &&
            j == (int'(last) + k) % N) begin
          found = 1'b1;
          win   = 2'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters to one UART tx.
// Ports: sys_clk, rst_n (async, active-low); req_valid/req_data/req_lock in,
// req_ready one-hot accept pulse; tx_data/tx_start to the transmitter,
// tx_busy back; grant_id last winner; ack_err sticky launch-timeout flag.
// Option: define UART_TX_ARB_LOCK_EN to let a granted requester hold the
// grant via req_lock.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                           sys_clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_lock,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]         tx_data,
  output logic                           tx_start,
  input  logic                           tx_busy,
  output logic [1:0]                     grant_id,
  output logic                           ack_err
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  arb_state_t             state;
  logic [CW-1:0]          to_cnt;
  logic [NUM_REQ-1:0]     gid_oh;
  logic [NUM_REQ-1:0]     win_oh;
  logic [NUM_REQ-1:0]     pick_req;
  logic [1:0]             win;
  logic                   found;
  logic [UART_BYTE_W-1:0] win_data;
  logic                   lock_hold;
  logic                   lock_next;

  always_comb begin
    gid_oh   = '0;
    win_oh   = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gid_oh[i] = (grant_id == 2'(i));
      win_oh[i] = (win == 2'(i));
      if (win == 2'(i))
        win_data = req_data[UART_BYTE_W*i +: UART_BYTE_W];
    end
  end

  // lock_next: value the lock takes when the FSM re-enters IDLE
  assign lock_next = |(gid_oh & req_lock);

`ifdef UART_TX_ARB_LOCK_EN
  logic lock;
  assign lock_hold = lock & lock_next;
`else
  wire unused_lock = lock_next;
  assign lock_hold = 1'b0;
`endif

  // While locked, only the lock holder may win (or nobody).
  assign pick_req = lock_hold ? (req_valid & gid_oh) : req_valid;

  rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req  (pick_req),
    .last (grant_id),
    .win  (win),
    .found(found)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tx_start  <= 1'b0;
      req_ready <= '0;
      tx_data   <= '0;
      grant_id  <= 2'(NUM_REQ - 1);
      ack_err   <= 1'b0;
      to_cnt    <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      lock      <= 1'b0;
`endif
    end else begin
      tx_start  <= 1'b0;
      req_ready <= '0;
      unique case (state)
        ST_IDLE: begin
`ifdef UART_TX_ARB_LOCK_EN
          lock <= lock_hold;
`endif
          if (!tx_busy && found) begin
            req_ready <= win_oh;
            tx_data   <= win_data;
            grant_id  <= win;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tx_start <= 1'b1;
          to_cnt   <= '0;
          state    <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (tx_busy) begin
            to_cnt <= '0;
            state  <= ST_WAIT_DONE;
          end else if (to_cnt == CW'(ACK_TIMEOUT - 1)) begin
            ack_err <= 1'b1;
            to_cnt  <= '0;
            state   <= ST_IDLE;
`ifdef UART_TX_ARB_LOCK_EN
            lock    <= lock_next;
`endif
          end else begin
            to_cnt <= to_cnt + CW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            state <= ST_IDLE;
`ifdef UART_TX_ARB_LOCK_EN
            lock  <= lock_next;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a busy-for-10-cycles tx model.
// Launch order and payloads are queued by stimulus and checked by a monitor.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N    = 2;
  localparam int TO   = 16;
  localparam int BUSY = 10;

  logic           sys_clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_lock = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           ack_err;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .ACK_TIMEOUT(TO)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_lock (req_lock),
    .req_ready(req_ready),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .grant_id (grant_id),
    .ack_err  (ack_err)
  );

  always #5 sys_clk = ~sys_clk;

  int busy_cnt = 0;
  bit model_en = 1'b1;
  bit force_busy = 1'b0;

  always @(posedge sys_clk) begin
    if (model_en && tx_start) busy_cnt <= BUSY;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy || (busy_cnt != 0);

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp_v);
    end
  endtask

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;
  exp_t sbq[$];

  task automatic expect_tx(input int id, input int d);
    exp_t e;
    e.id   = 2'(id);
    e.data = 8'(d);
    sbq.push_back(e);
  endtask

  logic [N-1:0] prev_rdy = '0;
  int n_start = 0;
  int n_rdy1 = 0;
  exp_t mon_e;

  always @(negedge sys_clk) begin
    if (!rst_n) begin
      prev_rdy = '0;
    end else begin
      if (req_ready[1]) n_rdy1++;
      if (tx_start) begin
        n_start++;
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_start: got byte %02h id %0d, required none",
                   tx_data, grant_id);
        end else begin
          mon_e = sbq.pop_front();
          chk("tx_data", 32'(tx_data), 32'(mon_e.data));
          chk("grant_id", 32'(grant_id), 32'(mon_e.id));
          chk("ready_before_start", 32'(prev_rdy), 32'(1) << mon_e.id);
          chk("start_while_idle_tx", 32'(tx_busy), 32'(0));
        end
      end
      prev_rdy = req_ready;
    end
  end

  task automatic wait_ready(input int id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (req_ready[id]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_ready%0d: got no pulse, required one", id);
    end
  endtask

  task automatic send(input int id, input int d);
    bit ok;
    req_data[8*id +: 8] = 8'(d);
    req_valid[id] = 1'b1;
    wait_ready(id, ok);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_start();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_start: got no tx_start, required one");
    end
  endtask

  task automatic settle();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 400 && quiet < 3; i++) begin
      @(negedge sys_clk);
      if (sbq.size() == 0 && !tx_busy) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) begin
      n_chk++;
      n_fail++;
      $display("FAIL settle: got %0d pending bytes, required 0", sbq.size());
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'(0));
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(0));
    chk({tag, "_tx_data"}, 32'(tx_data), 32'(0));
    chk({tag, "_grant_id"}, 32'(grant_id), 32'(N - 1));
    chk({tag, "_ack_err"}, 32'(ack_err), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int k;
    int s0;
    int r;
    int s1;
    int idx1;
    bit ok;

    #12;
    chk_reset_outs("rst");
    @(negedge sys_clk);
    rst_n = 1'b1;

    // contention: strict alternation starting at requester 0
    expect_tx(0, 'h41);
    expect_tx(1, 'h42);
    expect_tx(0, 'h41);
    expect_tx(1, 'h42);
    req_data = {8'h42, 8'h41};
    req_valid = 2'b11;
    cnt = 0;
    for (int i = 0; i < 300 && cnt < 4; i++) begin
      @(negedge sys_clk);
      if (|req_ready) cnt++;
    end
    req_valid = '0;
    chk("contention_accepts", 32'(cnt), 32'(4));
    settle();

    // single requester, byte held after completion
    expect_tx(0, 'h55);
    send(0, 'h55);
    wait_start();
    repeat (5) @(negedge sys_clk);
    chk("tx_data_hold", 32'(tx_data), 32'h55);
    settle();
    chk("tx_data_after", 32'(tx_data), 32'h55);

    // launch timeout
    chk("ack_err_pre", 32'(ack_err), 32'(0));
    model_en = 1'b0;
    expect_tx(0, 'h77);
    send(0, 'h77);
    wait_start();
    for (k = 1; k <= 40; k++) begin
      @(negedge sys_clk);
      if (ack_err) break;
    end
    chk("timeout_cycles", 32'(k), 32'(TO));
    model_en = 1'b1;
    expect_tx(1, 'h99);
    send(1, 'h99);
    settle();
    chk("ack_err_sticky", 32'(ack_err), 32'(1));

    // withdraw: req1 pulses valid during a transfer
    s1 = n_rdy1;
    expect_tx(0, 'hA0);
    send(0, 'hA0);
    wait_start();
    repeat (2) @(negedge sys_clk);
    req_data[15:8] = 8'hB1;
    req_valid[1] = 1'b1;
    repeat (4) @(negedge sys_clk);
    req_valid[1] = 1'b0;
    settle();
    chk("withdraw_no_ready1", 32'(n_rdy1 - s1), 32'(0));

    // lock
`ifdef UART_TX_ARB_LOCK_EN
    expect_tx(1, 'h31);
    expect_tx(1, 'h32);
    expect_tx(1, 'h33);
    expect_tx(0, 'h30);
`else
    expect_tx(1, 'h31);
    expect_tx(0, 'h30);
    expect_tx(1, 'h32);
    expect_tx(1, 'h33);
`endif
    req_data = {8'h31, 8'h30};
    req_lock[1] = 1'b1;
    req_valid = 2'b11;
    idx1 = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (req_ready[1]) begin
        idx1++;
        if (idx1 == 3) begin
          req_valid[1] = 1'b0;
          req_lock[1] = 1'b0;
        end else begin
          req_data[15:8] = 8'(8'h31 + idx1);
        end
      end
      if (req_ready[0]) req_valid[0] = 1'b0;
      if (idx1 == 3 && !req_valid[0]) break;
    end
    chk("lock_req1_accepts", 32'(idx1), 32'(3));
    settle();

    // reset while the transmitter is busy
    expect_tx(0, 'h66);
    send(0, 'h66);
    wait_start();
    repeat (4) @(negedge sys_clk);
    force_busy = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    @(negedge sys_clk);
    rst_n = 1'b1;
    s0 = n_start;
    r = 0;
    req_data[7:0] = 8'h67;
    req_valid[0] = 1'b1;
    repeat (12) begin
      @(negedge sys_clk);
      if (|req_ready) r++;
    end
    chk("post_rst_no_start", 32'(n_start - s0), 32'(0));
    chk("post_rst_no_ready", 32'(r), 32'(0));
    expect_tx(0, 'h67);
    force_busy = 1'b0;
    wait_ready(0, ok);
    req_valid[0] = 1'b0;
    settle();

    chk("sb_empty", 32'(sbq.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of byte requesters (2..4).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16: max sys_clk cycles to wait for tx_busy after tx_start.
REQ-003 SHALL have port sys_clk  in  1  system clock, 27 MHz, all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  NUM_REQ  per-requester byte available.
REQ-006 SHALL have port req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 SHALL have port req_lock  in  NUM_REQ  per-requester hold-grant request; ignored unless UART_TX_ARB_LOCK_EN.
REQ-008 SHALL have port req_ready  out  NUM_REQ  one-hot, one-cycle byte-accept pulse.
REQ-009 SHALL have port tx_data  out  8  byte to the shared UART transmitter.
REQ-010 SHALL have port tx_start  out  1  one-cycle launch pulse to the transmitter.
REQ-011 SHALL have port tx_busy  in  1  transmitter busy, high from launch until stop bit ends.
REQ-012 SHALL have port grant_id  out  2  index of current or last granted requester.
REQ-013 SHALL have port ack_err  out  1  sticky flag: transmitter never raised tx_busy.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> WAIT_ACK -> WAIT_DONE -> IDLE.
REQ-015 IDLE: if tx_busy low and any req_valid high, SHALL select winner, pulse req_ready[winner], latch its byte into tx_data, set grant_id, go ISSUE; if tx_busy high, SHALL stay IDLE.
REQ-016 Arbitration SHALL be round-robin: search starts at grant_id+1 mod NUM_REQ; after reset the first search starts at index 0.
REQ-017 ISSUE SHALL assert tx_start for exactly one cycle, then go WAIT_ACK; latency from req_ready pulse to tx_start SHALL be 1 cycle.
REQ-018 WAIT_ACK SHALL go WAIT_DONE on tx_busy high; after ACK_TIMEOUT cycles without it SHALL set ack_err and go IDLE.
REQ-019 WAIT_DONE SHALL go IDLE on the first cycle tx_busy is low.
REQ-020 tx_data SHALL hold stable from ISSUE until the next acceptance.
REQ-021 Simultaneous requests SHALL accept exactly one byte per pass through the FSM; non-winners see no req_ready.
REQ-022 A requester dropping req_valid before acceptance SHALL simply lose its turn; no byte is sent for it.
REQ-023 ack_err SHALL clear only on reset.

Reset
REQ-024 On rst_n low, asynchronously: state IDLE, tx_start 0, req_ready 0, tx_data 0x00, grant_id NUM_REQ-1 (so the first search starts at 0), ack_err 0, lock flag 0, timeout counter 0.
REQ-025 Reset mid-transfer SHALL abandon the byte; the first post-reset grant SHALL wait for tx_busy low.

Configuration
REQ-026 With UART_TX_ARB_LOCK_EN defined:
- if the granted requester has req_lock high on entering IDLE, the arbiter SHALL grant only that requester until its req_lock is low in IDLE;
- while it holds the lock with req_valid low, others SHALL wait.
REQ-027 Without UART_TX_ARB_LOCK_EN, req_lock SHALL be ignored and the lock flag SHALL not exist.

Structure
REQ-028 A shared package uart_pkg SHALL hold:
- FSM state enum;
- UART_BYTE_W = 8;
- BAUD_DIV = 2813 (9600 baud at 27 MHz), so transmitter and arbiter agree.
REQ-029 Round-robin winner selection SHALL be sub-module rr_pick: combinational, inputs req vector and last index, outputs winner index and found flag.

Verification
REQ-030 Single requester: req0 sends 0x55 with a transmitter model busy for 10 cycles -> one req_ready[0] pulse, tx_start 1 cycle later, tx_data 0x55, back in IDLE once busy drops.
REQ-031 Contention: req0=0x41 and req1=0x42 both held valid -> launch order 0x41, 0x42, 0x41, 0x42, with no back-to-back grants to one requester.
REQ-032 Timeout: tx_busy held 0 -> ack_err set exactly ACK_TIMEOUT cycles after tx_start, FSM in IDLE, next request still served.
REQ-033 Reset mid-WAIT_DONE with busy high -> all outputs at reset values; after release, no tx_start until tx_busy low.
REQ-034 Lock: with UART_TX_ARB_LOCK_EN, req1 locks and sends 0x31, 0x32, 0x33 while req0 is valid -> req0 served only after req1 drops req_lock; without the macro the bytes interleave.
REQ-035 Withdraw: req1 raises then drops req_valid while a byte is in flight -> no req_ready[1] and no byte sent for req1.
